axis_bist_src: RTL

Built-in self-test stimulus source that sits directly upstream of the FIR top level and drives its AXI4-Stream slave input. On a START pulse it emits NUM_PKTS packets of NUM_OF_SAMPLES signed samples each, from a selectable deterministic pattern, with TLAST on the final sample of every packet. It replaces the external AXI master during on-board BIST, so the FIR chain can be exercised with known vectors.

---
 rtl/axis_bist_src.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/axis_bist_src.sv
// AXI4-Stream BIST stimulus source: emits NUM_PKTS packets of ramp/impulse/square/LFSR samples.
// Build option AXIS_BIST_LFSR_EN adds the MODE=11 LFSR pattern; without it MODE=11 repeats the ramp.
module axis_bist_src #(
  parameter int DATA_WIDTH     = 16,
  parameter int NUM_OF_SAMPLES = 2000,
  parameter int SQ_HALF_PERIOD = 16
) (
  input  logic                  M_AXIS_ACLK,
  input  logic                  M_AXIS_ARESETN,
  input  logic                  START,
  input  logic [1:0]            MODE,
  input  logic [7:0]            NUM_PKTS,
  output logic                  BUSY,
  output logic                  DONE,
  input  logic                  M_AXIS_TREADY,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TLAST,
  output logic                  M_AXIS_TVALID
);

  localparam int IDX_W    = $clog2(NUM_OF_SAMPLES);
  localparam int SQ_SHIFT = $clog2(SQ_HALF_PERIOD);
  localparam logic [IDX_W-1:0]      LAST_IDX    = IDX_W'(NUM_OF_SAMPLES - 1);
  localparam logic [IDX_W-1:0]      IDX_ZERO    = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0]      IDX_ONE     = IDX_W'(1'b1);
  localparam logic [DATA_WIDTH-1:0] ZERO_VAL    = {DATA_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] IMPULSE_VAL = {2'b01, {(DATA_WIDTH-2){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] SQ_POS_VAL  = {3'b001, {(DATA_WIDTH-3){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] SQ_NEG_VAL  = {3'b111, {(DATA_WIDTH-3){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Index-driven patterns; MODE=11 lands in the ramp branch unless overridden by the LFSR.
  function automatic logic [DATA_WIDTH-1:0] idx_pattern(input logic [1:0] mode,
                                                        input logic [IDX_W-1:0] idx);
    logic                  odd_half;
    logic [DATA_WIDTH-1:0] val;
    odd_half = ((32'(idx) >> SQ_SHIFT) & 32'd1) != 32'd0;
    case (mode)
      2'b00:   val = DATA_WIDTH'(idx);
      2'b01:   val = (idx == IDX_ZERO) ? IMPULSE_VAL : ZERO_VAL;
      2'b10:   val = odd_half ? SQ_NEG_VAL : SQ_POS_VAL;
      default: val = DATA_WIDTH'(idx);
    endcase
    return val;
  endfunction

`ifdef AXIS_BIST_LFSR_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: taps land on bits 0,2,3,5.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] lfsr_data(input logic [15:0] s);
    return DATA_WIDTH'($signed(s));
  endfunction

  logic [15:0] lfsr_r;
  logic [15:0] nxt_lfsr_s;
`endif

  state_t                 state_r;
  logic [IDX_W-1:0]       idx_r;
  logic [7:0]             pc_r;
  logic [1:0]             mode_r;
  logic [7:0]             npkts_r;
  logic [DATA_WIDTH-1:0]  tdata_r;
  logic                   tlast_r;
  logic                   tvalid_r;
  logic                   busy_r;
  logic                   done_r;

  logic                   xfer_s;
  logic                   wrap_s;
  logic                   finish_s;
  logic [IDX_W-1:0]       nxt_idx_s;
  logic [DATA_WIDTH-1:0]  nxt_data_s;
  logic [DATA_WIDTH-1:0]  start_data_s;

  // Next-beat index, pattern sample and end-of-run decode.
  always_comb begin
    xfer_s   = tvalid_r & M_AXIS_TREADY;
    wrap_s   = (idx_r == LAST_IDX);
    finish_s = xfer_s & wrap_s & (npkts_r != 8'd0) & ((pc_r + 8'd1) == npkts_r);
    if (wrap_s) begin
      nxt_idx_s = IDX_ZERO;
    end else begin
      nxt_idx_s = idx_r + IDX_ONE;
    end
`ifdef AXIS_BIST_LFSR_EN
    if (wrap_s) begin
      nxt_lfsr_s = LFSR_SEED;
    end else begin
      nxt_lfsr_s = lfsr_step(lfsr_r);
    end
    if (mode_r == 2'b11) begin
      nxt_data_s = lfsr_data(nxt_lfsr_s);
    end else begin
      nxt_data_s = idx_pattern(mode_r, nxt_idx_s);
    end
    if (MODE == 2'b11) begin
      start_data_s = lfsr_data(LFSR_SEED);
    end else begin
      start_data_s = idx_pattern(MODE, IDX_ZERO);
    end
`else
    nxt_data_s   = idx_pattern(mode_r, nxt_idx_s);
    start_data_s = idx_pattern(MODE, IDX_ZERO);
`endif
  end

  // Run control FSM with registered stream and status outputs.
  always_ff @(posedge M_AXIS_ACLK) begin
    if (!M_AXIS_ARESETN) begin
      state_r  <= IDLE;
      idx_r    <= IDX_ZERO;
      pc_r     <= 8'd0;
      mode_r   <= 2'b00;
      npkts_r  <= 8'd0;
      tdata_r  <= ZERO_VAL;
      tlast_r  <= 1'b0;
      tvalid_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
`ifdef AXIS_BIST_LFSR_EN
      lfsr_r   <= 16'h0000;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (START) begin
            state_r  <= RUN;
            mode_r   <= MODE;
            npkts_r  <= NUM_PKTS;
            idx_r    <= IDX_ZERO;
            pc_r     <= 8'd0;
            tdata_r  <= start_data_s;
            tlast_r  <= 1'b0;
            tvalid_r <= 1'b1;
            busy_r   <= 1'b1;
`ifdef AXIS_BIST_LFSR_EN
            lfsr_r   <= LFSR_SEED;
`endif
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          if (finish_s) begin
            state_r  <= FINISH;
            tvalid_r <= 1'b0;
            tlast_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            idx_r    <= IDX_ZERO;
            pc_r     <= 8'd0;
          end else if (xfer_s) begin
            idx_r   <= nxt_idx_s;
            tdata_r <= nxt_data_s;
            tlast_r <= (nxt_idx_s == LAST_IDX);
            if (wrap_s) begin
              pc_r <= pc_r + 8'd1;
            end else begin
              pc_r <= pc_r;
            end
`ifdef AXIS_BIST_LFSR_EN
            lfsr_r  <= nxt_lfsr_s;
`endif
          end else begin
            state_r <= RUN;
          end
        end
        FINISH: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
        end
        default: begin
          state_r  <= IDLE;
          tvalid_r <= 1'b0;
          tlast_r  <= 1'b0;
          busy_r   <= 1'b0;
          done_r   <= 1'b0;
        end
      endcase
    end
  end

  assign M_AXIS_TDATA  = tdata_r;
  assign M_AXIS_TLAST  = tlast_r;
  assign M_AXIS_TVALID = tvalid_r;
  assign BUSY          = busy_r;
  assign DONE          = done_r;

endmodule
